pll_reset_ctrl: RTL

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the system reset. Lock losses and lock timeouts are tracked.
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2      // must be at least 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t RST_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLLRST,
        WAITLOCK,
        STABLE,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic [7:0]             relock_d;
    logic                   timeout_d;

    // pll_locked comes from another clock domain; only the last flop of the chain is used.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        relock_d  = relock_count;
        timeout_d = timeout_err;
        unique case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAITLOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            WAITLOCK: begin
                // A lock arriving on the timeout cycle wins over the timeout.
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLLRST;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAITLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                    if (relock_count != 8'hFF) begin
                        relock_d = relock_count + 8'd1;
                    end
                end
            end
            default: begin
                state_d = PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= PLLRST;
            cnt_q        <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst      <= (state_d == PLLRST);
            sys_rst      <= (state_d != RUN);
            ready        <= (state_d == RUN);
            relock_count <= relock_d;
            timeout_err  <= timeout_d;
        end
    end

endmodule
